// File: rtl/cu_wb_sched_if.sv
// Sequencer/unit <-> write-back scheduler bundle; master = sequencer and result units,
// slave = scheduler. Units hold req/wadd until their gnt; sequencer holds issue while stalled.
interface cu_wb_sched_if #(
  parameter int ADDRESS_WIDTH = 4,
  parameter int SIGNAL_WIDTH  = 3
);
  logic                     ps_sch_issue;
  logic [ADDRESS_WIDTH-1:0] ps_sch_wadd;
  logic [ADDRESS_WIDTH-1:0] ps_sch_raddx;
  logic [ADDRESS_WIDTH-1:0] ps_sch_raddy;
  logic                     ps_sch_rxEn;
  logic                     ps_sch_ryEn;

  logic                     alu_sch_req;
  logic                     mul_sch_req;
  logic                     shf_sch_req;
  logic                     bc_sch_req;
  logic [ADDRESS_WIDTH-1:0] alu_sch_wadd;
  logic [ADDRESS_WIDTH-1:0] mul_sch_wadd;
  logic [ADDRESS_WIDTH-1:0] shf_sch_wadd;
  logic [ADDRESS_WIDTH-1:0] bc_sch_wadd;

  logic                     sch_alu_gnt;
  logic                     sch_mul_gnt;
  logic                     sch_shf_gnt;
  logic                     sch_bc_gnt;
  logic [SIGNAL_WIDTH-1:0]  sch_xb_w_cuEn;
  logic                     sch_xb_w_bcEn;
  logic [ADDRESS_WIDTH-1:0] sch_rf_wadd;
  logic                     sch_ps_stall;
  logic                     sch_err;

  modport master (
    output ps_sch_issue, ps_sch_wadd, ps_sch_raddx, ps_sch_raddy, ps_sch_rxEn, ps_sch_ryEn,
    output alu_sch_req, mul_sch_req, shf_sch_req, bc_sch_req,
    output alu_sch_wadd, mul_sch_wadd, shf_sch_wadd, bc_sch_wadd,
    input  sch_alu_gnt, sch_mul_gnt, sch_shf_gnt, sch_bc_gnt,
    input  sch_xb_w_cuEn, sch_xb_w_bcEn, sch_rf_wadd, sch_ps_stall, sch_err
  );

  modport slave (
    input  ps_sch_issue, ps_sch_wadd, ps_sch_raddx, ps_sch_raddy, ps_sch_rxEn, ps_sch_ryEn,
    input  alu_sch_req, mul_sch_req, shf_sch_req, bc_sch_req,
    input  alu_sch_wadd, mul_sch_wadd, shf_sch_wadd, bc_sch_wadd,
    output sch_alu_gnt, sch_mul_gnt, sch_shf_gnt, sch_bc_gnt,
    output sch_xb_w_cuEn, sch_xb_w_bcEn, sch_rf_wadd, sch_ps_stall, sch_err
  );
endinterface

// File: rtl/cu_wb_sched.sv
// RF write-port arbiter (bc first, then round-robin ALU/MUL/SHF) plus RAW/WAW scoreboard.
// Zero-cycle req->gnt; ungranted units hold req/wadd, sequencer is backpressured by sch_ps_stall.
module cu_wb_sched #(
  parameter int ADDRESS_WIDTH = 4,
  parameter int SIGNAL_WIDTH  = 3
) (
  input  logic         clk_dcd,
  input  logic         rst_n,
  cu_wb_sched_if.slave sch
);
  localparam int DEPTH = 2 ** ADDRESS_WIDTH;

  typedef logic [ADDRESS_WIDTH-1:0] addr_t;
  typedef enum logic [1:0] {CU_ALU = 2'd0, CU_MUL = 2'd1, CU_SHF = 2'd2} cu_e;

  logic [DEPTH-1:0]        pend_q, pend_d;
  cu_e                     last_cu_q, last_cu_d;
  logic                    err_q, err_d;
  logic                    gnt_alu, gnt_mul, gnt_shf, gnt_bc, gnt_any;
  logic [SIGNAL_WIDTH-1:0] cu_en;
  addr_t                   rf_wadd;
  logic                    hit_x, hit_y, hit_w;
  logic                    raw_x, raw_y, waw, stall;

  // Nothing is granted while held in reset; bc pre-empts the CU rotation.
  always_comb begin
    gnt_alu   = 1'b0;
    gnt_mul   = 1'b0;
    gnt_shf   = 1'b0;
    gnt_bc    = 1'b0;
    last_cu_d = last_cu_q;
    if (rst_n) begin
      if (sch.bc_sch_req) begin
        gnt_bc = 1'b1;
      end else begin
        case (last_cu_q)
          CU_ALU: begin
            if (sch.mul_sch_req)      gnt_mul = 1'b1;
            else if (sch.shf_sch_req) gnt_shf = 1'b1;
            else if (sch.alu_sch_req) gnt_alu = 1'b1;
          end
          CU_MUL: begin
            if (sch.shf_sch_req)      gnt_shf = 1'b1;
            else if (sch.alu_sch_req) gnt_alu = 1'b1;
            else if (sch.mul_sch_req) gnt_mul = 1'b1;
          end
          default: begin
            if (sch.alu_sch_req)      gnt_alu = 1'b1;
            else if (sch.mul_sch_req) gnt_mul = 1'b1;
            else if (sch.shf_sch_req) gnt_shf = 1'b1;
          end
        endcase
      end
    end
    if (gnt_alu)      last_cu_d = CU_ALU;
    else if (gnt_mul) last_cu_d = CU_MUL;
    else if (gnt_shf) last_cu_d = CU_SHF;
  end

  assign gnt_any = gnt_alu | gnt_mul | gnt_shf | gnt_bc;
  assign cu_en   = {gnt_shf, gnt_mul, gnt_alu};

  always_comb begin
    rf_wadd = '0;
    if (gnt_bc)       rf_wadd = sch.bc_sch_wadd;
    else if (gnt_alu) rf_wadd = sch.alu_sch_wadd;
    else if (gnt_mul) rf_wadd = sch.mul_sch_wadd;
    else if (gnt_shf) rf_wadd = sch.shf_sch_wadd;
  end

  // A register being written this cycle is forwarded by the crossbar, so it is not a hazard.
  always_comb begin
    hit_x = gnt_any && (rf_wadd == sch.ps_sch_raddx);
    hit_y = gnt_any && (rf_wadd == sch.ps_sch_raddy);
    hit_w = gnt_any && (rf_wadd == sch.ps_sch_wadd);
    raw_x = sch.ps_sch_rxEn && pend_q[sch.ps_sch_raddx] && !hit_x;
    raw_y = sch.ps_sch_ryEn && pend_q[sch.ps_sch_raddy] && !hit_y;
    waw   = pend_q[sch.ps_sch_wadd] && !hit_w;
    stall = rst_n && sch.ps_sch_issue && (raw_x || raw_y || waw);
  end

  // Set after clear: a new issue to the register being written leaves it pending.
  always_comb begin
    pend_d = pend_q;
    if (gnt_any) pend_d[rf_wadd] = 1'b0;
    if (sch.ps_sch_issue && !stall) pend_d[sch.ps_sch_wadd] = 1'b1;
    err_d = err_q | (gnt_any & ~pend_q[rf_wadd]);
  end

  always_ff @(posedge clk_dcd or negedge rst_n) begin
    if (!rst_n) begin
      pend_q    <= '0;
      last_cu_q <= CU_SHF;
      err_q     <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      last_cu_q <= last_cu_d;
      err_q     <= err_d;
    end
  end

  assign sch.sch_alu_gnt   = gnt_alu;
  assign sch.sch_mul_gnt   = gnt_mul;
  assign sch.sch_shf_gnt   = gnt_shf;
  assign sch.sch_bc_gnt    = gnt_bc;
  assign sch.sch_xb_w_cuEn = cu_en;
  assign sch.sch_xb_w_bcEn = gnt_bc;
  assign sch.sch_rf_wadd   = rf_wadd;
  assign sch.sch_ps_stall  = stall;
  assign sch.sch_err       = err_q;

  a_onehot: assert property (@(posedge clk_dcd) $onehot0({gnt_bc, gnt_shf, gnt_mul, gnt_alu}));

  // An ungranted requester must keep its request and destination until granted.
  a_alu_hold: assert property (@(posedge clk_dcd) (rst_n && sch.alu_sch_req && !gnt_alu)
    |=> (!rst_n || (sch.alu_sch_req && $stable(sch.alu_sch_wadd))));
  a_mul_hold: assert property (@(posedge clk_dcd) (rst_n && sch.mul_sch_req && !gnt_mul)
    |=> (!rst_n || (sch.mul_sch_req && $stable(sch.mul_sch_wadd))));
  a_shf_hold: assert property (@(posedge clk_dcd) (rst_n && sch.shf_sch_req && !gnt_shf)
    |=> (!rst_n || (sch.shf_sch_req && $stable(sch.shf_sch_wadd))));
  a_bc_hold: assert property (@(posedge clk_dcd) (rst_n && sch.bc_sch_req && !gnt_bc)
    |=> (!rst_n || (sch.bc_sch_req && $stable(sch.bc_sch_wadd))));
endmodule

// File: tb/tb_cu_wb_sched.sv
// Bench for cu_wb_sched: vector table drives one cycle per row, expected outputs go
// through a scoreboard queue; hand sequences cover reset mid-operation.
module tb_cu_wb_sched;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  cu_wb_sched_if #(.ADDRESS_WIDTH(4), .SIGNAL_WIDTH(3)) bus ();

  cu_wb_sched #(.ADDRESS_WIDTH(4), .SIGNAL_WIDTH(3)) dut (
    .clk_dcd (clk),
    .rst_n   (rst_n),
    .sch     (bus)
  );

  // req / gnt nibbles are {bc, shf, mul, alu}; pend is the scoreboard seen before the edge.
  typedef struct {
    int issue, wadd, raddx, rxen, raddy, ryen;
    int req, alu_w, mul_w, shf_w, bc_w;
    int gnt, cuen, bcen, radd, stall, err, pend;
  } vec_t;

  typedef struct {
    int idx;
    int gnt, cuen, bcen, radd, stall, err, pend;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(input int issue, wadd, raddx, rxen, raddy, ryen,
                              input int req, alu_w, mul_w, shf_w, bc_w,
                              input int gnt, cuen, bcen, radd, stall, err, pend);
    vec_t t;
    t.issue = issue; t.wadd = wadd; t.raddx = raddx; t.rxen = rxen;
    t.raddy = raddy; t.ryen = ryen; t.req = req;
    t.alu_w = alu_w; t.mul_w = mul_w; t.shf_w = shf_w; t.bc_w = bc_w;
    t.gnt = gnt; t.cuen = cuen; t.bcen = bcen; t.radd = radd;
    t.stall = stall; t.err = err; t.pend = pend;
    return t;
  endfunction

  task automatic idle_inputs();
    bus.ps_sch_issue = 1'b0; bus.ps_sch_wadd = '0;
    bus.ps_sch_raddx = '0;   bus.ps_sch_raddy = '0;
    bus.ps_sch_rxEn  = 1'b0; bus.ps_sch_ryEn  = 1'b0;
    bus.alu_sch_req  = 1'b0; bus.mul_sch_req  = 1'b0;
    bus.shf_sch_req  = 1'b0; bus.bc_sch_req   = 1'b0;
    bus.alu_sch_wadd = '0;   bus.mul_sch_wadd = '0;
    bus.shf_sch_wadd = '0;   bus.bc_sch_wadd  = '0;
  endtask

  task automatic drive(input vec_t t);
    bus.ps_sch_issue = t.issue[0];
    bus.ps_sch_wadd  = 4'(t.wadd);
    bus.ps_sch_raddx = 4'(t.raddx);
    bus.ps_sch_rxEn  = t.rxen[0];
    bus.ps_sch_raddy = 4'(t.raddy);
    bus.ps_sch_ryEn  = t.ryen[0];
    bus.alu_sch_req  = t.req[0];
    bus.mul_sch_req  = t.req[1];
    bus.shf_sch_req  = t.req[2];
    bus.bc_sch_req   = t.req[3];
    bus.alu_sch_wadd = 4'(t.alu_w);
    bus.mul_sch_wadd = 4'(t.mul_w);
    bus.shf_sch_wadd = 4'(t.shf_w);
    bus.bc_sch_wadd  = 4'(t.bc_w);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%0h expected=%0h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input exp_t e);
    chk("gnt",   e.idx, 32'({bus.sch_bc_gnt, bus.sch_shf_gnt, bus.sch_mul_gnt, bus.sch_alu_gnt}), 32'(e.gnt));
    chk("cuEn",  e.idx, 32'(bus.sch_xb_w_cuEn), 32'(e.cuen));
    chk("bcEn",  e.idx, 32'(bus.sch_xb_w_bcEn), 32'(e.bcen));
    chk("wadd",  e.idx, 32'(bus.sch_rf_wadd),   32'(e.radd));
    chk("stall", e.idx, 32'(bus.sch_ps_stall),  32'(e.stall));
    chk("err",   e.idx, 32'(bus.sch_err),       32'(e.err));
    chk("pend",  e.idx, 32'(dut.pend_q),        32'(e.pend));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    //             iss wa  rx xe ry ye  req    aw mw sw bw   gnt    cu  bc ra st er pend
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 'b0000, 0, 0, 0, 0, 'b0000, 0, 0, 0, 0, 0, 'h0000));
    vecs.push_back(mk(1, 2, 0, 0, 0, 0, 'b0000, 0, 0, 0, 0, 'b0000, 0, 0, 0, 0, 0, 'h0002));
    vecs.push_back(mk(1, 3, 0, 0, 0, 0, 'b0000, 0, 0, 0, 0, 'b0000, 0, 0, 0, 0, 0, 'h0006));
    // round robin ALU, MUL, SHF, ALU; the ALU write of 1 collides with a reissue of 1
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 'b0111, 1, 2, 3, 0, 'b0001, 1, 0, 1, 0, 0, 'h000E));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 'b0111, 1, 2, 3, 0, 'b0010, 2, 0, 2, 0, 0, 'h000E));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 'b0101, 1, 0, 3, 0, 'b0100, 4, 0, 3, 0, 0, 'h000A));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 'b0001, 1, 0, 0, 0, 'b0001, 1, 0, 1, 0, 0, 'h0002));
    // bc priority over ALU, ALU next cycle
    vecs.push_back(mk(1, 5, 0, 0, 0, 0, 'b0000, 0, 0, 0, 0, 'b0000, 0, 0, 0, 0, 0, 'h0000));
    vecs.push_back(mk(1, 6, 0, 0, 0, 0, 'b0000, 0, 0, 0, 0, 'b0000, 0, 0, 0, 0, 0, 'h0020));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 'b1001, 6, 0, 0, 5, 'b1000, 0, 1, 5, 0, 0, 'h0060));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 'b0001, 6, 0, 0, 0, 'b0001, 1, 0, 6, 0, 0, 'h0040));
    // RAW on x, released by MUL write-back bypass
    vecs.push_back(mk(1, 4, 0, 0, 0, 0, 'b0000, 0, 0, 0, 0, 'b0000, 0, 0, 0, 0, 0, 'h0000));
    vecs.push_back(mk(1, 8, 4, 1, 0, 0, 'b0000, 0, 0, 0, 0, 'b0000, 0, 0, 0, 1, 0, 'h0010));
    vecs.push_back(mk(1, 8, 4, 1, 0, 0, 'b0010, 0, 4, 0, 0, 'b0010, 2, 0, 4, 0, 0, 'h0010));
    // RAW on y, released by SHF; disabled reads never stall
    vecs.push_back(mk(1, 7, 8, 0, 8, 1, 'b0000, 0, 0, 0, 0, 'b0000, 0, 0, 0, 1, 0, 'h0100));
    vecs.push_back(mk(1, 7, 8, 0, 8, 1, 'b0100, 0, 0, 8, 0, 'b0100, 4, 0, 8, 0, 0, 'h0100));
    vecs.push_back(mk(1,10, 7, 0, 7, 0, 'b0000, 0, 0, 0, 0, 'b0000, 0, 0, 0, 0, 0, 'h0080));
    // WAW stall, then reissue of 7 in the cycle ALU writes 7
    vecs.push_back(mk(1, 7, 0, 0, 0, 0, 'b0000, 0, 0, 0, 0, 'b0000, 0, 0, 0, 1, 0, 'h0480));
    vecs.push_back(mk(1, 7, 0, 0, 0, 0, 'b0001, 7, 0, 0, 0, 'b0001, 1, 0, 7, 0, 0, 'h0480));
    vecs.push_back(mk(1,11,10, 1, 0, 0, 'b1000, 0, 0, 0,10, 'b1000, 0, 1,10, 0, 0, 'h0480));
    // write to a non-pending register: sticky error
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 'b0100, 0, 0, 9, 0, 'b0100, 4, 0, 9, 0, 0, 'h0880));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 'b0000, 0, 0, 0, 0, 'b0000, 0, 0, 0, 0, 1, 'h0880));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 'b0001, 7, 0, 0, 0, 'b0001, 1, 0, 7, 0, 1, 'h0880));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 'b0000, 0, 0, 0, 0, 'b0000, 0, 0, 0, 0, 1, 'h0800));

    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    e = '{idx: -1, gnt: 0, cuen: 0, bcen: 0, radd: 0, stall: 0, err: 0, pend: 0};
    chk_all(e);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i]);
      sb.push_back('{idx: i, gnt: vecs[i].gnt, cuen: vecs[i].cuen, bcen: vecs[i].bcen,
                     radd: vecs[i].radd, stall: vecs[i].stall, err: vecs[i].err,
                     pend: vecs[i].pend});
      @(negedge clk);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty vec=%0d actual=0 expected=1", i);
      end else begin
        chk_all(sb.pop_front());
      end
    end

    // Reset mid-operation with a bc request and a hazardous issue on the pins.
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.bc_sch_req   = 1'b1; bus.bc_sch_wadd  = 4'd3;
    bus.ps_sch_issue = 1'b1; bus.ps_sch_wadd  = 4'd11;
    bus.ps_sch_raddx = 4'd11; bus.ps_sch_rxEn = 1'b1;
    @(negedge clk);
    e = '{idx: 100, gnt: 0, cuen: 0, bcen: 0, radd: 0, stall: 0, err: 0, pend: 0};
    chk_all(e);
    @(posedge clk);
    #1;
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;

    @(posedge clk);
    #1;
    bus.ps_sch_issue = 1'b1; bus.ps_sch_wadd = 4'd3;
    @(negedge clk);
    chk("post_rst_stall", 101, 32'(bus.sch_ps_stall), 32'd0);
    chk("post_rst_err",   101, 32'(bus.sch_err),      32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("post_rst_waw",   102, 32'(bus.sch_ps_stall), 32'd1);
    chk("post_rst_pend",  102, 32'(dut.pend_q),       32'h0008);
    @(posedge clk);
    #1;
    idle_inputs();
    @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
